// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Shares one external 8-bit ALU between two requesters. Each requester
//   offers an operation through a valid/ready handshake. Arbitration is
//   round-robin. A 16-bit (wide) operation runs as two chained 8-bit passes.
//   The issuing requester gets a one-cycle response pulse.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake (N = 0, 1)
//   reqN_op/wide/a/b/ci        request payload
//   rspN_valid                 one-cycle response pulse to the issuer
//   rsp_data, rsp_cout         result, held until the next response
//   alu_a/b/ci/mode            drive to the shared ALU (registered only)
//   alu_s, alu_cout            combinational result from the shared ALU
//   busy                       high whenever the sequencer is not idle
module alu_scheduler #(
   parameter int LONG_OPS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic        req0_wide,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic        req0_ci,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic        req1_wide,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   input  logic        req1_ci,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_cout,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic        alu_ci,
   output logic [3:0]  alu_mode,
   input  logic [7:0]  alu_s,
   input  logic        alu_cout,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t      state;
   logic        last_grant;   // 1 = req1 was granted last
   logic        id_q;         // requester that owns the current op
   logic [3:0]  op_q;
   logic        wide_q;
   logic [7:0]  a_hi;         // upper operand bytes, used by the HI pass
   logic [7:0]  b_hi;
   logic        ci_q;
   logic [7:0]  res_lo;

   logic        grant1;
   logic        accept;
   logic [3:0]  sel_op;
   logic        sel_wide;
   logic [15:0] sel_a;
   logic [15:0] sel_b;
   logic        sel_ci;
   logic        chain;

   // Round-robin pick: a lone requester wins; on contention the one not
   // granted last wins.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path can leave it unassigned and infer a latch.
      grant1 = 1'b0;
      if (req0_valid && req1_valid)
         grant1 = ~last_grant;
      else
         grant1 = req1_valid;
   end

   // Ready is gated by rst_n so that no request is acknowledged while reset
   // is held, even though the valids may already be high.
   assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
   assign req0_ready = accept & ~grant1;
   assign req1_ready = accept &  grant1;

   assign sel_op   = grant1 ? req1_op   : req0_op;
   assign sel_wide = (grant1 ? req1_wide : req0_wide) & (LONG_OPS != 0);
   assign sel_a    = grant1 ? req1_a    : req0_a;
   assign sel_b    = grant1 ? req1_b    : req0_b;
   assign sel_ci   = grant1 ? req1_ci   : req0_ci;

   // Carry chains into the high pass only for add and sub.
   assign chain = (op_q[3:1] == 3'b000);

   // The ALU drive, response and busy outputs are all registered and are
   // loaded on the transition into the state that presents them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         id_q       <= 1'b0;
         op_q       <= '0;
         wide_q     <= 1'b0;
         a_hi       <= '0;
         b_hi       <= '0;
         ci_q       <= 1'b0;
         res_lo     <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_data   <= '0;
         rsp_cout   <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ci     <= 1'b0;
         alu_mode   <= '0;
         busy       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register samples values from before the edge.
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= LO;
                  busy       <= 1'b1;
                  last_grant <= grant1;
                  id_q       <= grant1;
                  op_q       <= sel_op;
                  wide_q     <= sel_wide;
                  a_hi       <= sel_a[15:8];
                  b_hi       <= sel_b[15:8];
                  ci_q       <= sel_ci;
                  alu_a      <= sel_a[7:0];
                  alu_b      <= sel_b[7:0];
                  alu_ci     <= sel_ci;
                  alu_mode   <= sel_op;
               end
            end
            LO: begin
               res_lo <= alu_s;
               if (wide_q) begin
                  state    <= HI;
                  alu_a    <= a_hi;
                  alu_b    <= b_hi;
                  alu_ci   <= chain ? alu_cout : ci_q;
                  alu_mode <= op_q;
               end else begin
                  state      <= DONE;
                  alu_a      <= '0;
                  alu_b      <= '0;
                  alu_ci     <= 1'b0;
                  alu_mode   <= '0;
                  rsp_data   <= {8'h00, alu_s};
                  rsp_cout   <= alu_cout;
                  rsp0_valid <= ~id_q;
                  rsp1_valid <=  id_q;
               end
            end
            HI: begin
               state      <= DONE;
               alu_a      <= '0;
               alu_b      <= '0;
               alu_ci     <= 1'b0;
               alu_mode   <= '0;
               rsp_data   <= {alu_s, res_lo};
               rsp_cout   <= alu_cout;
               rsp0_valid <= ~id_q;
               rsp1_valid <=  id_q;
            end
            DONE: begin
               state      <= IDLE;
               busy       <= 1'b0;
               rsp0_valid <= 1'b0;
               rsp1_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler
//   Directed bench for alu_scheduler. A small behavioural ALU answers the
//   scheduler's alu_* drive; expected values are hand-computed constants.
module tb_alu_scheduler;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_op, req1_op;
   logic        req0_wide, req1_wide;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_ci, req1_ci;
   logic        rsp0_valid, rsp1_valid;
   logic [15:0] rsp_data;
   logic        rsp_cout;
   logic [7:0]  alu_a, alu_b;
   logic        alu_ci;
   logic [3:0]  alu_mode;
   logic [7:0]  alu_s;
   logic        alu_cout;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   alu_scheduler #(.LONG_OPS(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_wide  (req0_wide),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ci    (req0_ci),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_wide  (req1_wide),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ci    (req1_ci),
      .rsp0_valid (rsp0_valid),
      .rsp1_valid (rsp1_valid),
      .rsp_data   (rsp_data),
      .rsp_cout   (rsp_cout),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ci     (alu_ci),
      .alu_mode   (alu_mode),
      .alu_s      (alu_s),
      .alu_cout   (alu_cout),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU: add, sub (a + ~b + ci), and, or; other codes give xor.
   always_comb begin
      alu_s    = '0;
      alu_cout = 1'b0;
      case (alu_mode)
         4'b0000: {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
         4'b0001: {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_ci};
         4'b0010: alu_s = alu_a & alu_b;
         4'b0011: alu_s = alu_a | alu_b;
         default: alu_s = alu_a ^ alu_b;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [3:0] op, input logic w,
                           input logic [15:0] a, input logic [15:0] b, input logic ci);
      req0_valid = v; req0_op = op; req0_wide = w; req0_a = a; req0_b = b; req0_ci = ci;
   endtask

   task automatic set_req1(input logic v, input logic [3:0] op, input logic w,
                           input logic [15:0] a, input logic [15:0] b, input logic ci);
      req1_valid = v; req1_op = op; req1_wide = w; req1_a = a; req1_b = b; req1_ci = ci;
   endtask

   logic [8:0] c_r0, c_r1, c_s0, c_s1;
   logic [5:0] b_r0, b_busy, b_s0;

   initial begin
      rst_n = 1'b1;
      set_req0(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
      set_req1(1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
      #1 rst_n = 1'b0;
      #1;

      // ---- Reset values
      check("rst_busy",  busy, 0);
      check("rst_ready", {req0_ready, req1_ready}, 0);
      check("rst_rsp",   {rsp0_valid, rsp1_valid}, 0);
      check("rst_data",  {rsp_cout, rsp_data}, 0);
      check("rst_alu",   {alu_a, alu_b, alu_ci, alu_mode}, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // ---- Narrow add, req0: 0xab + 0xcb = 0x176
      set_req0(1'b1, 4'b0000, 1'b0, 16'h00ab, 16'h00cb, 1'b0);
      #1;
      check("n_ready0", req0_ready, 1);
      check("n_ready1", req1_ready, 0);
      check("n_busy_T", busy, 0);
      tick();                                  // T+1 LO
      req0_valid = 1'b0;
      check("n_lo_a",    alu_a, 8'hab);
      check("n_lo_b",    alu_b, 8'hcb);
      check("n_lo_mode", alu_mode, 0);
      check("n_lo_busy", busy, 1);
      check("n_lo_rsp",  rsp0_valid, 0);
      tick();                                  // T+2 DONE
      check("n_rsp0",  rsp0_valid, 1);
      check("n_rsp1",  rsp1_valid, 0);
      check("n_data",  rsp_data, 16'h0076);
      check("n_cout",  rsp_cout, 1);
      tick();                                  // T+3 IDLE
      check("n_rsp0_end", rsp0_valid, 0);
      check("n_busy_end", busy, 0);
      check("n_hold",     rsp_data, 16'h0076);

      // ---- Wide add, req1: 0x6fff + 0x0001 = 0x7000
      set_req1(1'b1, 4'b0000, 1'b1, 16'h6fff, 16'h0001, 1'b0);
      #1;
      check("w_ready1", req1_ready, 1);
      tick();                                  // LO
      req1_valid = 1'b0;
      check("w_lo_ab", {alu_a, alu_b}, 16'hff01);
      check("w_lo_ci", alu_ci, 0);
      tick();                                  // HI
      check("w_hi_ci", alu_ci, 1);
      check("w_hi_a",  alu_a, 8'h6f);
      check("w_hi_b",  alu_b, 8'h00);
      check("w_hi_rsp", rsp1_valid, 0);
      tick();                                  // T+3 DONE
      check("w_rsp1", rsp1_valid, 1);
      check("w_rsp0", rsp0_valid, 0);
      check("w_data", rsp_data, 16'h7000);
      check("w_cout", rsp_cout, 0);
      tick();

      // ---- Wide AND, req0: 0xabcd & 0x0ff0 = 0x0bc0, ci passes through
      set_req0(1'b1, 4'b0010, 1'b1, 16'habcd, 16'h0ff0, 1'b1);
      #1;
      check("and_ready0", req0_ready, 1);
      tick();                                  // LO
      req0_valid = 1'b0;
      check("and_lo_ci",   alu_ci, 1);
      check("and_lo_mode", alu_mode, 4'b0010);
      tick();                                  // HI
      check("and_hi_ci",   alu_ci, 1);
      check("and_hi_a",    alu_a, 8'hab);
      check("and_hi_mode", alu_mode, 4'b0010);
      tick();                                  // DONE
      check("and_rsp0", rsp0_valid, 1);
      check("and_data", rsp_data, 16'h0bc0);
      tick();

      // ---- Contention right after reset: req0, req1, req0 ...
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_req0(1'b1, 4'b0000, 1'b0, 16'h0001, 16'h0002, 1'b0);
      set_req1(1'b1, 4'b0011, 1'b0, 16'h0010, 16'h0020, 1'b0);
      #1;
      c_r0 = 9'b001000001;
      c_r1 = 9'b000001000;
      c_s0 = 9'b100000100;
      c_s1 = 9'b000100000;
      for (int k = 0; k < 9; k++) begin
         if (k == 7) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         check($sformatf("c_ready0_%0d", k), req0_ready, c_r0[k]);
         check($sformatf("c_ready1_%0d", k), req1_ready, c_r1[k]);
         check($sformatf("c_rsp0_%0d", k), rsp0_valid, c_s0[k]);
         check($sformatf("c_rsp1_%0d", k), rsp1_valid, c_s1[k]);
         if (k == 2) check("c_data_k2", rsp_data, 16'h0003);
         if (k == 5) check("c_data_k5", rsp_data, 16'h0030);
         tick();
      end

      // ---- Reset during HI of a wide op (last grant is req0 here)
      set_req0(1'b1, 4'b0000, 1'b1, 16'h1234, 16'h1111, 1'b0);
      #1;
      check("r_ready0", req0_ready, 1);
      tick();                                  // LO
      tick();                                  // HI
      check("r_hi_a", alu_a, 8'h12);
      #2 rst_n = 1'b0;
      req1_valid = 1'b1;
      #1;
      check("r_busy",  busy, 0);
      check("r_alu",   {alu_a, alu_b, alu_ci, alu_mode}, 0);
      check("r_rsp",   {rsp0_valid, rsp1_valid}, 0);
      check("r_data",  {rsp_cout, rsp_data}, 0);
      check("r_ready", {req0_ready, req1_ready}, 0);
      for (int k = 0; k < 2; k++) begin
         tick();
         check($sformatf("r_hold_rsp_%0d", k), {rsp0_valid, rsp1_valid}, 0);
      end
      rst_n = 1'b1;
      #1;
      check("r_post_ready0", req0_ready, 1);
      check("r_post_ready1", req1_ready, 0);
      tick();                                  // LO
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();                                  // HI
      tick();                                  // DONE
      check("r_post_rsp0", rsp0_valid, 1);
      check("r_post_data", rsp_data, 16'h2345);
      tick();

      // ---- Back-to-back narrow ops, req0 held valid
      set_req0(1'b1, 4'b0000, 1'b0, 16'h0012, 16'h0034, 1'b0);
      #1;
      b_r0   = 6'b001001;
      b_busy = 6'b110110;
      b_s0   = 6'b100100;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("b_ready0_%0d", k), req0_ready, b_r0[k]);
         check($sformatf("b_busy_%0d", k), busy, b_busy[k]);
         check($sformatf("b_rsp0_%0d", k), rsp0_valid, b_s0[k]);
         if (b_s0[k]) check($sformatf("b_data_%0d", k), rsp_data, 16'h0046);
         tick();
      end
      req0_valid = 1'b0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencer and round-robin arbiter that shares the 8-bit `alu` datapath (operands `a`/`b`, carry-in `ci`, 4-bit `aluMode`, result `s`, carry-out `cout`) between two requesters. It accepts one operation at a time through a valid/ready handshake and drives the ALU operand and mode inputs from registered state. It chains two ALU passes to execute 16-bit (wide) operations, then returns a one-cycle response pulse to the requester that issued the operation. It sits between the requesting logic and the single shared `alu` instance.

## Interface
- `LONG_OPS`, default 1: 1 enables two-pass 16-bit operations; 0 treats `reqN_wide` as 0.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req0_valid` / `req1_valid`  in  1  request present; held stable with its payload until ready.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_op` / `req1_op`  in  4  ALU mode: 0000 add, 0001 sub, 0010 and, 0011 or; other codes are passed through unchanged.
- `req0_wide` / `req1_wide`  in  1  1 = 16-bit operation (two passes); 0 = 8-bit.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  16  operands; for narrow ops only [7:0] is used.
- `req0_ci` / `req1_ci`  in  1  carry-in for the low pass.
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle result pulse to the issuing requester.
- `rsp_data`  out  16  result; [15:8] = 0 for narrow ops.
- `rsp_cout`  out  1  carry-out of the final pass.
- `alu_a`, `alu_b`  out  8  ALU operands.
- `alu_ci`  out  1  ALU carry-in.
- `alu_mode`  out  4  ALU mode.
- `alu_s`  in  8  ALU result (combinational, same cycle).
- `alu_cout`  in  1  ALU carry-out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE → LO on accept.
  - LO → HI when the captured wide flag is 1; LO → DONE when it is 0.
  - HI → DONE.
  - DONE → IDLE.
- IDLE:
  - If any `reqN_valid` is high, grant exactly one requester and assert its `reqN_ready` combinationally in that cycle.
  - Capture op, wide, a, b, ci and the grant ID.
  - Arbitration: a lone valid requester wins. If both are valid, the requester not granted last wins. After reset the last-grant pointer is 1, so req0 wins first.
- LO:
  - Drive `alu_a`=a[7:0], `alu_b`=b[7:0], `alu_ci`=ci, `alu_mode`=op.
  - Register `alu_s` into res_lo and `alu_cout` into carry.
- HI:
  - Drive `alu_a`=a[15:8], `alu_b`=b[15:8], `alu_mode`=op.
  - `alu_ci` = registered carry when op is 0000 or 0001; otherwise `alu_ci` = captured ci.
  - Register `alu_s` into res_hi and `alu_cout` into carry.
- DONE:
  - Pulse `rspN_valid` for the granted ID.
  - `rsp_data` = {res_hi, res_lo}, with res_hi cleared on narrow ops.
  - `rsp_cout` = carry.
- ALU outputs depend only on state registers; there is no combinational path from `req*` inputs to `alu_*`. In IDLE and DONE all `alu_*` outputs are 0.
- No response backpressure: the requester must sample in the pulse cycle.

## Timing
- Accept in cycle T (IDLE, ready high).
- LO occupies cycle T+1. A wide op occupies HI at T+2.
- `rspN_valid` is high in T+2 for narrow ops and T+3 for wide ops, for exactly one cycle.
- The next accept is possible no earlier than T+3 (narrow) or T+4 (wide). Accepts happen only in IDLE.
- `rsp_data`/`rsp_cout` hold their last values until the next DONE.
- Reset values: state IDLE, last-grant pointer 1, and all outputs 0 (`reqN_ready`, `rspN_valid`, `rsp_data`, `rsp_cout`, `alu_*`, `busy`). Internal capture registers are also 0.
- Reset asserted mid-operation aborts immediately: no response is ever issued for the aborted op, and the requester must re-present it.
- Valid deasserted while the block is not in IDLE has no effect. Only the request captured at accept is executed.

## Test plan
- Narrow add, req0: a=0x00ab, b=0x00cb, op=0000, ci=0, accepted at T.
  - T+1: `alu_a`=ab, `alu_b`=cb, `alu_mode`=0.
  - T+2: `rsp0_valid`=1, `rsp_data`=0x0076, `rsp_cout`=1.
- Wide add, req1: a=0x6fff, b=0x0001, ci=0.
  - LO: `alu_s`=00 with `alu_cout`=1.
  - HI: `alu_ci`=1, `alu_a`=6f.
  - T+3: `rsp1_valid`=1, `rsp_data`=0x7000, `rsp_cout`=0.
- Contention: both valid after reset.
  - req0 is granted at T and req1 at T+3; with both held, grants continue to alternate.
  - A `reqN_ready` is never high for both requesters in the same cycle.
- Wide AND: a=0xabcd, b=0x0ff0, op=0010, ci=1.
  - HI drives `alu_ci`=1, the captured ci, not the chained carry.
  - Response: `rsp_data`=0x0bc0.
- Reset during HI of a wide op:
  - All outputs are 0 at once and neither `rspN_valid` pulses.
  - The next request after release is accepted from IDLE, with req0 preferred.
- Back-to-back narrow ops, req0 only, valid held: accepts at T and T+3, with responses at T+2 and T+5; `busy` is low only in the accept cycles.
